dmem_arbiter: RTL

- Shares the single-port byte-addressed data memory between two requesters: port 0 (CPU load/store stage) and port 1 (DMA/program loader).
- Arbitrates one access per cycle, registers the winning command, and drives the memory's WE/A/WD.
- Captures read data and returns it with a one-cycle rvalid pulse.
- Sits between the pipeline MEM stage, the loader, and the data memory.

---
 rtl/dmem_arbiter_if.sv | 62 ++++++
 rtl/dmem_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - bus bundle between requesters, data memory and dmem_arbiter
//
// Purpose: groups the two requester ports, the memory-side command/read-data
// bus and the error pulses into one interface.
//   slave  modport : used by dmem_arbiter (takes requests and mem_rd, drives
//                    grants, responses, memory command and error pulses)
//   master modport : used by the environment (requesters plus data memory)
// Port summary:
//   pX_req/pX_op/pX_addr/pX_wdata : requester command, held until pX_gnt
//   pX_gnt                        : combinational accept for this cycle
//   pX_rvalid/pX_rdata            : one-cycle load response, rdata held after
//   mem_we/mem_a/mem_wd           : registered memory command (op encoding)
//   mem_rd                        : asynchronous memory read data
//   err_illegal/err_misalign      : one-cycle error pulses in the issue cycle
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  p0_req;
  logic [2:0]            p0_op;
  logic [ADDR_WIDTH-1:0] p0_addr;
  logic [DATA_WIDTH-1:0] p0_wdata;
  logic                  p0_gnt;
  logic                  p0_rvalid;
  logic [DATA_WIDTH-1:0] p0_rdata;

  logic                  p1_req;
  logic [2:0]            p1_op;
  logic [ADDR_WIDTH-1:0] p1_addr;
  logic [DATA_WIDTH-1:0] p1_wdata;
  logic                  p1_gnt;
  logic                  p1_rvalid;
  logic [DATA_WIDTH-1:0] p1_rdata;

  logic [2:0]            mem_we;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic [DATA_WIDTH-1:0] mem_rd;

  logic                  err_illegal;
  logic                  err_misalign;

  modport slave (
    input  p0_req, p0_op, p0_addr, p0_wdata,
    input  p1_req, p1_op, p1_addr, p1_wdata,
    input  mem_rd,
    output p0_gnt, p0_rvalid, p0_rdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_we, mem_a, mem_wd,
    output err_illegal, err_misalign
  );

  modport master (
    output p0_req, p0_op, p0_addr, p0_wdata,
    output p1_req, p1_op, p1_addr, p1_wdata,
    output mem_rd,
    input  p0_gnt, p0_rvalid, p0_rdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_we, mem_a, mem_wd,
    input  err_illegal, err_misalign
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter in front of a single-port data memory
//
// Purpose: accepts at most one request per cycle from port 0 (CPU) or port 1
// (DMA/loader), registers the winning command, issues it to the memory the
// next cycle, and returns load data with a one-cycle rvalid the cycle after.
// Read latency is two cycles from acceptance; one acceptance per cycle.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : dmem_arbiter_if.slave (requester ports, memory bus, error pulses)
// Configuration:
//   DMEM_ARB_RR_EN defined   -> round-robin between the two ports
//   DMEM_ARB_RR_EN undefined -> fixed priority, port 0 wins
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_arbiter_if.slave   bus
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_SW  = 3'b001;
  localparam logic [2:0] OP_LB  = 3'b010;
  localparam logic [2:0] OP_SB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b110;

  function automatic logic op_legal(input logic [2:0] op);
    case (op)
      OP_LW, OP_SW, OP_LB, OP_SB, OP_LBU: op_legal = 1'b1;
      default:                            op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_load(input logic [2:0] op);
    op_is_load = (op == OP_LW) || (op == OP_LB) || (op == OP_LBU);
  endfunction

  logic gnt0, gnt1, accept;

  assign accept = gnt0 | gnt1;

`ifdef DMEM_ARB_RR_EN
  // last_q holds the port accepted most recently; under contention the other
  // port wins. Reset value 1 makes port 0 win the first contention.
  logic last_q, last_d;

  assign gnt0   = bus.p0_req && (!bus.p1_req || last_q);
  assign gnt1   = bus.p1_req && (!bus.p0_req || !last_q);
  assign last_d = accept ? gnt1 : last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`else
  assign gnt0 = bus.p0_req;
  assign gnt1 = bus.p1_req && !bus.p0_req;
`endif

  assign bus.p0_gnt = gnt0;
  assign bus.p1_gnt = gnt1;

  // Winning command, selected by the grant.
  logic [2:0]            sel_op;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  assign sel_op    = gnt1 ? bus.p1_op    : bus.p0_op;
  assign sel_addr  = gnt1 ? bus.p1_addr  : bus.p0_addr;
  assign sel_wdata = gnt1 ? bus.p1_wdata : bus.p0_wdata;

  // Issue-stage registers. The memory command is stored already decoded so
  // that idle and illegal commands appear as all-zero on the memory bus and
  // an asynchronous reset forces mem_we to 000 immediately.
  logic [2:0]            mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic [DATA_WIDTH-1:0] mem_wd_q, mem_wd_d;
  logic                  load_q, load_d;
  logic                  port_q, port_d;
  logic                  err_ill_q, err_ill_d;
  logic                  err_mis_q, err_mis_d;

  // Response-stage registers.
  logic                  rvalid0_q, rvalid0_d;
  logic                  rvalid1_q, rvalid1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

  always_comb begin
    mem_we_d  = 3'b000;
    mem_a_d   = '0;
    mem_wd_d  = '0;
    load_d    = 1'b0;
    port_d    = gnt1;
    err_ill_d = 1'b0;
    err_mis_d = 1'b0;

    if (accept) begin
      if (op_legal(sel_op)) begin
        mem_we_d  = sel_op;
        mem_a_d   = sel_addr;
        mem_wd_d  = sel_wdata;
        load_d    = op_is_load(sel_op);
        // Misaligned words go out unchanged; the memory aligns down.
        err_mis_d = ((sel_op == OP_LW) || (sel_op == OP_SW)) &&
                    (sel_addr[1:0] != 2'b00);
      end else begin
        err_ill_d = 1'b1;
      end
    end

    // mem_rd belongs to the load being issued now; capture it for its port.
    rvalid0_d = load_q && !port_q;
    rvalid1_d = load_q &&  port_q;
    rdata0_d  = rvalid0_d ? bus.mem_rd : rdata0_q;
    rdata1_d  = rvalid1_d ? bus.mem_rd : rdata1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we_q  <= 3'b000;
      mem_a_q   <= '0;
      mem_wd_q  <= '0;
      load_q    <= 1'b0;
      port_q    <= 1'b0;
      err_ill_q <= 1'b0;
      err_mis_q <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      mem_we_q  <= mem_we_d;
      mem_a_q   <= mem_a_d;
      mem_wd_q  <= mem_wd_d;
      load_q    <= load_d;
      port_q    <= port_d;
      err_ill_q <= err_ill_d;
      err_mis_q <= err_mis_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign bus.mem_we       = mem_we_q;
  assign bus.mem_a        = mem_a_q;
  assign bus.mem_wd       = mem_wd_q;
  assign bus.err_illegal  = err_ill_q;
  assign bus.err_misalign = err_mis_q;
  assign bus.p0_rvalid    = rvalid0_q;
  assign bus.p0_rdata     = rdata0_q;
  assign bus.p1_rvalid    = rvalid1_q;
  assign bus.p1_rdata     = rdata1_q;

endmodule
